// File: rtl/iterative_divider_pkg.sv
// ============================================================================
// Module  : iterative_div_pkg
// Brief   : Shared state encoding and default widths for iterative_divider.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package iterative_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIVIDEND_W_DEF = 16;
   localparam int DIVISOR_W_DEF  = 8;
   localparam int CNT_W          = $clog2(DIVIDEND_W_DEF);

endpackage

`default_nettype wire

// File: rtl/iterative_divider_div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division iteration.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module div_step #(
   parameter int DIVISOR_W = 8
) (
   input  logic [DIVISOR_W-1:0] pr_in,
   input  logic                 dividend_bit,
   input  logic [DIVISOR_W-1:0] divisor,
   output logic [DIVISOR_W-1:0] pr_out,
   output logic                 qbit
);

   logic [DIVISOR_W:0] w_trial;
   logic [DIVISOR_W:0] w_diff;

   assign w_trial = {pr_in, dividend_bit};
   assign w_diff  = w_trial - {1'b0, divisor};
   assign qbit    = (w_trial >= {1'b0, divisor});

   // After a successful subtract the result is below the divisor, so the top bit is zero.
   assign pr_out  = qbit ? w_diff[DIVISOR_W-1:0] : w_trial[DIVISOR_W-1:0];

endmodule

`default_nettype wire

// File: rtl/iterative_divider.sv
// ============================================================================
// Module  : iterative_divider
// Brief   : Multi-cycle unsigned restoring divider, one quotient bit per clock.
//           Optional macro ITER_DIV_EARLY_DBZ_EN short-circuits a zero divisor.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module iterative_divider
   import iterative_div_pkg::*;
#(
   parameter int DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] in_dividend,
   input  logic [DIVISOR_W-1:0]  in_divisor,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] out_quotient,
   output logic [DIVISOR_W-1:0]  out_remainder
);

   localparam int                 c_CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIVIDEND_W - 1);

   state_t                r_state;
   logic [c_CNT_W-1:0]    r_count;
   logic [DIVIDEND_W-1:0] r_quo;
   logic [DIVISOR_W-1:0]  r_dvs;
   logic [DIVISOR_W-1:0]  r_pr;
   logic                  r_in_ready;
   logic                  r_out_valid;

   logic [DIVISOR_W-1:0]  w_pr_next;
   logic                  w_qbit;
   logic                  w_early_dbz;

`ifdef ITER_DIV_EARLY_DBZ_EN
   assign w_early_dbz = (in_divisor == '0);
`else
   assign w_early_dbz = 1'b0;
`endif

   // r_quo doubles as the dividend shift register: its MSB feeds the step,
   // quotient bits enter at the LSB.
   div_step #(
      .DIVISOR_W (DIVISOR_W)
   ) u_step (
      .pr_in        (r_pr),
      .dividend_bit (r_quo[DIVIDEND_W-1]),
      .divisor      (r_dvs),
      .pr_out       (w_pr_next),
      .qbit         (w_qbit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_count     <= '0;
         r_quo       <= '0;
         r_dvs       <= '0;
         r_pr        <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_dvs      <= in_divisor;
                  r_count    <= '0;
                  r_in_ready <= 1'b0;
                  if (w_early_dbz) begin
                     r_quo       <= '1;
                     r_pr        <= in_dividend[DIVISOR_W-1:0];
                     r_out_valid <= 1'b1;
                     r_state     <= DONE;
                  end else begin
                     r_quo   <= in_dividend;
                     r_pr    <= '0;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               r_pr    <= w_pr_next;
               r_quo   <= {r_quo[DIVIDEND_W-2:0], w_qbit};
               r_count <= r_count + 1'b1;
               if (r_count == c_LAST) begin
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_out_valid;
   assign out_quotient  = r_quo;
   assign out_remainder = r_pr;

endmodule

`default_nettype wire

// File: tb/tb_iterative_divider.sv
// ============================================================================
// Module  : tb_iterative_divider
// Brief   : Self-checking bench for iterative_divider against an arithmetic model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_iterative_divider;

`ifdef ITER_DIV_EARLY_DBZ_EN
   localparam int DBZ_LAT = 1;
`else
   localparam int DBZ_LAT = 17;
`endif
   localparam int RUN_LAT = 17;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] in_dividend = '0;
   logic [7:0]  in_divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] out_quotient;
   logic [7:0]  out_remainder;

   int tests_run    = 0;
   int tests_failed = 0;
   logic [23:0] exp_q[$];

   iterative_divider dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_dividend   (in_dividend),
      .in_divisor    (in_divisor),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_quotient  (out_quotient),
      .out_remainder (out_remainder)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
      end
   endtask

   // Result as {quotient, remainder}; zero divisor yields all-ones quotient and the dividend's low byte.
   function automatic logic [23:0] model(input logic [15:0] a, input logic [7:0] b);
      logic [15:0] q;
      logic [15:0] r;
      if (b == 8'd0) return {16'hFFFF, a[7:0]};
      q = a / {8'd0, b};
      r = a % {8'd0, b};
      return {q, r[7:0]};
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 32'd1, 32'd0);
         end else begin
            check("quotient", {16'd0, out_quotient}, {16'd0, exp_q[0][23:8]});
            check("remainder", {24'd0, out_remainder}, {24'd0, exp_q[0][7:0]});
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int hold, input int gap);
      int n;
      int edges;
      repeat (gap) @(negedge clk);
      @(negedge clk);
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         return;
      end
      in_dividend = a;
      in_divisor  = b;
      in_valid    = 1'b1;
      out_ready   = 1'b1;
      exp_q.push_back(model(a, b));
      @(posedge clk);
      #1;
      // Noise on the inputs while busy must be ignored.
      in_valid    = 1'($urandom_range(0, 1));
      in_dividend = 16'($urandom);
      in_divisor  = 8'($urandom);
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      edges = 1;
      while (!out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      in_valid = 1'b0;
      check("latency", edges, (b == 8'd0) ? DBZ_LAT : RUN_LAT);
      if (!out_valid) return;
      if (hold > 0) begin
         out_ready = 1'b0;
         repeat (hold) begin
            @(posedge clk);
            #1;
            check("held_valid", {31'd0, out_valid}, 32'd1);
            check("held_in_ready", {31'd0, in_ready}, 32'd0);
         end
         out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
      check("post_hs_valid", {31'd0, out_valid}, 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_quotient", {16'd0, out_quotient}, 32'd0);
      check("rst_remainder", {24'd0, out_remainder}, 32'd0);
      rst_n = 1'b1;

      check("model_1000_7", {8'd0, model(16'd1000, 8'd7)}, {8'd0, 16'd142, 8'd6});
      check("model_ffff_ff", {8'd0, model(16'hFFFF, 8'hFF)}, {8'd0, 16'd257, 8'd0});
      check("model_5_10", {8'd0, model(16'd5, 8'd10)}, {8'd0, 16'd0, 8'd5});
      check("model_1234_0", {8'd0, model(16'd1234, 8'd0)}, {8'd0, 16'hFFFF, 8'hD2});
      check("model_300_9", {8'd0, model(16'd300, 8'd9)}, {8'd0, 16'd33, 8'd3});

      do_op(16'd1000, 8'd7, 0, 0);
      do_op(16'hFFFF, 8'hFF, 0, 1);
      do_op(16'd5, 8'd10, 0, 0);
      do_op(16'd0, 8'd3, 0, 0);
      do_op(16'd1234, 8'd0, 0, 0);
      do_op(16'hFFFF, 8'd1, 0, 0);
      do_op(16'd40000, 8'd200, 5, 0);

      // Reset in the middle of a run drops the result.
      @(negedge clk);
      in_dividend = 16'd300;
      in_divisor  = 8'd9;
      in_valid    = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrun_rst_valid", {31'd0, out_valid}, 32'd0);
      check("midrun_rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      do_op(16'd300, 8'd9, 0, 0);

      for (int i = 0; i < 200; i++) begin
         do_op(16'($urandom), (i % 10 == 0) ? 8'd0 : 8'($urandom),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

`default_nettype wire
